// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes,
// FSM states, wait-state counter width and the lane byte-enable helper.
package dm_pkg;

  localparam logic [1:0] DM_SIZE_B = 2'b00;
  localparam logic [1:0] DM_SIZE_H = 2'b01;
  localparam logic [1:0] DM_SIZE_W = 2'b10;
  localparam logic [1:0] DM_SIZE_R = 2'b11;

  localparam int DM_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } dm_state_e;

  function automatic logic [3:0] dm_lane_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      DM_SIZE_B: be = 4'b0001 << lane;
      DM_SIZE_H: be = 4'b0011 << lane;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised RAM built from four byte banks; per-lane write enables and a
// registered word read that only updates on a read-enabled edge.
module dm_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] r_rdata;

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [7:0] r_bank [DEPTH];

    always_ff @(posedge clk) begin
      if (i_we[g]) begin
        r_bank[i_addr] <= i_wdata[8*g +: 8];
      end
    end

    // Only the read register is reset; bank contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rdata[8*g +: 8] <= 8'h00;
      end else if (i_re) begin
        r_rdata[8*g +: 8] <= r_bank[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_lsu.sv
// MEM-stage load/store unit: valid/ready request, WAIT stall cycles, one-cycle response pulse.
// Misalignment/reserved-size trapping is enabled by defining DM_ALIGN_CHECK_EN.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [DM_CNT_W-1:0] LP_WAIT = DM_CNT_W'(WAIT);

  dm_state_e             r_state;
  logic [DM_CNT_W-1:0]   r_cnt;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_W+1:0]     r_addr;
  logic [31:0]           r_wdata;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic                  r_rsp_load;
  logic [1:0]            r_rsp_size;
  logic                  r_rsp_signed;
  logic [1:0]            r_rsp_lane;

  logic                  w_fire;
  logic                  w_err;
  logic [1:0]            w_size_eff;
  logic [1:0]            w_lane;
  logic [31:0]           w_wdata;
  logic [3:0]            w_we;
  logic [31:0]           w_ram_rdata;
  logic [31:0]           w_shift;
  logic [31:0]           w_ext;
  logic                  w_unused_addr;

  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  assign w_fire = (r_state == ACC) && (r_cnt == '0);

`ifdef DM_ALIGN_CHECK_EN
  assign w_err = (r_size == DM_SIZE_R) ||
                 ((r_size == DM_SIZE_H) && r_addr[0]) ||
                 ((r_size == DM_SIZE_W) && (r_addr[1:0] != 2'b00));
  assign w_size_eff = r_size;
`else
  assign w_err = 1'b0;
  assign w_size_eff = (r_size == DM_SIZE_R) ? DM_SIZE_W : r_size;
`endif

  // Half/word lanes are force-aligned; with checking on, misaligned cases never reach the RAM.
  always_comb begin
    w_lane  = 2'b00;
    w_wdata = r_wdata;
    case (w_size_eff)
      DM_SIZE_B: begin
        w_lane  = r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      DM_SIZE_H: begin
        w_lane  = {r_addr[1], 1'b0};
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lane  = 2'b00;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign w_we = (w_fire && r_we && !w_err) ? dm_lane_be(w_size_eff, w_lane) : 4'b0000;

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_fire && !r_we),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Extension uses response-side copies so rdata holds while the next request is latched.
  always_comb begin
    w_shift = w_ram_rdata >> {r_rsp_lane, 3'b000};
    w_ext   = w_shift;
    case (r_rsp_size)
      DM_SIZE_B: w_ext = {{24{r_rsp_signed & w_shift[7]}}, w_shift[7:0]};
      DM_SIZE_H: w_ext = {{16{r_rsp_signed & w_shift[15]}}, w_shift[15:0]};
      default:   w_ext = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_size       <= DM_SIZE_B;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_load   <= 1'b0;
      r_rsp_size   <= DM_SIZE_B;
      r_rsp_signed <= 1'b0;
      r_rsp_lane   <= 2'b00;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr[ADDR_W+1:0];
            r_wdata  <= req_wdata;
            r_cnt    <= LP_WAIT;
            r_state  <= ACC;
          end
        end
        ACC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state      <= IDLE;
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= w_err;
            r_rsp_load   <= !r_we && !w_err;
            r_rsp_size   <= w_size_eff;
            r_rsp_signed <= r_signed;
            r_rsp_lane   <= w_lane;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_load ? w_ext : 32'h0000_0000;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: directed scenarios plus random traffic against a byte-array model,
// on a WAIT=0 instance and a WAIT=3 instance.
module tb_dm_lsu;

  localparam int AW = 10;
  localparam int MB = 4 * (1 << AW);
`ifdef DM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req_valid, req_ready, req_we, req_signed, rsp_valid, rsp_err, busy;
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int waits [2] = '{0, 3};
  logic [7:0] mem_m [2][MB];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_acc [2];

  always @(posedge clk) cyc <= cyc + 1;

  dm_lsu #(.ADDR_W(AW), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dm_lsu #(.ADDR_W(AW), .WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Little-endian byte memory; sizes are 1/2/4 bytes, reserved size acts as a word.
  function automatic void model(input int d, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int n;
    int ba;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ba = int'(a % MB);
    er = CHK && ((sz == 2'd3) || ((ba % n) != 0));
    rd = '0;
    if (!CHK) ba = ba - (ba % n);
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++) mem_m[d][ba + i] = 8'(wd >> (8 * i));
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[d][ba + i]) << (8 * i));
      if (sg && (n < 4) && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  task automatic acc(input int d, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input string tag,
                     output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int lat;
    chk({tag, "_rdy"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz; req_signed[d] = sg;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    t_acc[d] = cyc;
    #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom()); req_size[d] = 2'($urandom());
    req_signed[d] = 1'($urandom()); req_addr[d] = $urandom(); req_wdata[d] = $urandom();
    model(d, we, sz, sg, a, wd, exp_rd, exp_er);
    lat = 0;
    while (!rsp_valid[d] && lat <= 20) begin
      chk({tag, "_busy"}, 32'(busy[d]), 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(waits[d] + 1));
    chk({tag, "_rdata"}, rsp_rdata[d], exp_rd);
    chk({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_er));
    chk({tag, "_rdy_back"}, 32'(req_ready[d]), 32'd1);
    rd = rsp_rdata[d];
    er = rsp_err[d];
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    chk({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_busy"},  32'(busy[d]),      32'd0);
    chk({tag, "_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata[d],      32'd0);
    chk({tag, "_err"},   32'(rsp_err[d]),   32'd0);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        er, we, sg;
    logic [1:0]  sz;
    int          t0;

    rst = 2'b11; req_valid = 2'b00; req_we = 2'b00; req_signed = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_size[d] = 2'b00; req_addr[d] = '0; req_wdata[d] = '0;
      for (int i = 0; i < MB; i++) mem_m[d][i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(0, "rst0");
    chk_reset_vals(1, "rst3");
    rst = 2'b00;
    @(posedge clk);
    #1;

    for (int i = 0; i < 64; i++) acc(0, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'h0, "zero0", rd, er);
    for (int i = 0; i < 32; i++) acc(1, 1'b1, 2'd2, 1'b0, 32'(4 * i), 32'h0, "zero3", rd, er);

    acc(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, "sw10", rd, er);
    t0 = t_acc[0];
    acc(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10", rd, er);
    chk("b2b_gap", 32'(t_acc[0] - t0), 32'd2);
    chk("lw10_val", rd, 32'h1122_3344);
    @(posedge clk);
    #1;
    chk("hold_valid", 32'(rsp_valid[0]), 32'd0);
    chk("hold_rdata", rsp_rdata[0], 32'h1122_3344);

    acc(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, "sb13", rd, er);
    acc(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lb13", rd, er);
    chk("lb13_val", rd, 32'hFFFF_FF80);
    acc(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lbu13", rd, er);
    chk("lbu13_val", rd, 32'h0000_0080);
    acc(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10b", rd, er);
    chk("lw10b_val", rd, 32'h8022_3344);

    acc(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'hBEEF, "sh22", rd, er);
    acc(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "lh22", rd, er);
    chk("lh22_val", rd, 32'hFFFF_BEEF);
    acc(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "lhu22", rd, er);
    chk("lhu22_val", rd, 32'h0000_BEEF);
    acc(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw20", rd, er);
    chk("lw20_val", rd, 32'hBEEF_0000);

    acc(0, 1'b1, 2'd2, 1'b0, 32'h31, 32'hDEAD_BEEF, "sw31", rd, er);
    chk("sw31_err", 32'(er), 32'(CHK));
    chk("sw31_rdata", rd, 32'h0);
    acc(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "lw30", rd, er);
    chk("lw30_val", rd, CHK ? 32'h0 : 32'hDEAD_BEEF);

    acc(0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFE_F00D, "sw1000", rd, er);
    acc(0, 1'b0, 2'd2, 1'b0, 32'h0000, 32'h0, "lw0", rd, er);
    chk("wrap_val", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom()); sz = 2'($urandom()); sg = 1'($urandom());
      a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      wd = $urandom();
      acc(0, we, sz, sg, a, wd, "rnd0", rd, er);
    end

    acc(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0102_0304, "sw40_w3", rd, er);
    for (int i = 0; i < 20; i++) begin
      we = 1'($urandom()); sz = 2'($urandom()); sg = 1'($urandom());
      a  = 32'($urandom_range(0, 127)); wd = $urandom();
      acc(1, we, sz, sg, a, wd, "rnd3", rd, er);
    end
    acc(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0102_0304, "sw40b_w3", rd, er);
    acc(1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0, "sw44z_w3", rd, er);

    // Store accepted, then reset lands before it can commit: must be dropped.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2; req_signed[1] = 1'b0;
    req_addr[1] = 32'h44; req_wdata[1] = 32'h55AA_55AA;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("w3_busy_acc", 32'(busy[1]), 32'd1);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    #1;
    chk_reset_vals(1, "midrst");
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    acc(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, "lw44_w3", rd, er);
    chk("dropped_store", rd, 32'h0);
    acc(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "lw40_w3", rd, er);
    chk("ram_kept", rd, 32'h0102_0304);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
